// File: rtl/led_scan_mux_if.sv
// Signal bundle between a display controller (master) and the LED scan driver (slave).
// Carries the display value, the scan controls, and the decoder/anode outputs.
interface led_scan_mux_if #(
    parameter int NDIGITS = 4
);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp_in;
    logic                   lz_blank;
    logic                   enable;
    logic [3:0]             hex;
    logic                   dp;
    logic [NDIGITS-1:0]     an;
    logic [IDX_W-1:0]       digit_idx;

    modport master (
        output load, value, dp_in, lz_blank, enable,
        input  hex, dp, an, digit_idx
    );

    modport slave (
        input  load, value, dp_in, lz_blank, enable,
        output hex, dp, an, digit_idx
    );
endinterface

// File: rtl/led_scan_mux.sv
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment display,
// with inter-digit blanking, leading-zero suppression and scan pause.
module led_scan_mux #(
    parameter int NDIGITS      = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    led_scan_mux_if.slave bus
);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_BLANK = PS_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

    logic [4*NDIGITS-1:0] shadow_val;
    logic [NDIGITS-1:0]   shadow_dp;
    logic [PS_W-1:0]      presc;
    logic [IDX_W-1:0]     idx;

    logic [3:0]           hex_p1;
    logic                 dp_p1;
    logic [NDIGITS-1:0]   an_p1;

    logic [NDIGITS-1:0]   suppress;
    logic                 zero_tail;
    logic                 lit;
    logic                 slot_end;

    function automatic logic [NDIGITS-1:0] anode_sel(input logic [IDX_W-1:0] sel);
        logic [NDIGITS-1:0] mask;
        mask      = '1;
        mask[sel] = 1'b0;
        return mask;
    endfunction

    // A digit is a leading zero when it and every more-significant digit are
    // zero with no decimal point; digit 0 always stays lit.
    always_comb begin
        zero_tail = 1'b1;
        suppress  = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_tail   = zero_tail && (shadow_val[4*i +: 4] == 4'd0) && !shadow_dp[i];
            suppress[i] = bus.lz_blank && zero_tail && (i != 0);
        end
    end

    assign lit      = bus.enable && (presc >= PS_BLANK) && !suppress[idx];
    assign slot_end = (presc == PS_LAST);

    // Stage p0 -> p1: shadow capture, slot counter, and registered display outputs
    // all computed from the pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            presc      <= '0;
            idx        <= '0;
            hex_p1     <= 4'd0;
            dp_p1      <= 1'b1;
            an_p1      <= '1;
        end else begin
            if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp  <= bus.dp_in;
            end
            if (bus.enable) begin
                if (slot_end) begin
                    presc <= '0;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end else begin
                    presc <= presc + PS_W'(1);
                end
            end
            hex_p1 <= shadow_val[4*idx +: 4];
            dp_p1  <= ~shadow_dp[idx];
            an_p1  <= lit ? anode_sel(idx) : '1;
        end
    end

    assign bus.hex       = hex_p1;
    assign bus.dp        = dp_p1;
    assign bus.an        = an_p1;
    assign bus.digit_idx = idx;
endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench for led_scan_mux with NDIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_led_scan_mux;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    led_scan_mux_if #(.NDIGITS(4)) bus ();

    led_scan_mux #(
        .NDIGITS      (4),
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One paused edge captures the shadow without moving the slot counter.
    task automatic load_paused(input logic [15:0] v, input logic [3:0] d);
        bus.load   = 1'b1;
        bus.value  = v;
        bus.dp_in  = d;
        bus.enable = 1'b0;
        tick();
        bus.load   = 1'b0;
        bus.enable = 1'b1;
    endtask

    // Full frame from prescaler=0, digit 0; tables hold one nibble/bit per slot.
    task automatic run_frame(input string name, input logic [15:0] an_tab,
                             input logic [15:0] hex_tab, input logic [3:0] dp_tab);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                check($sformatf("%s an s%0d c%0d", name, k, c), 16'(bus.an),
                      (c < 2) ? 16'hF : 16'(an_tab[4*k +: 4]));
                check($sformatf("%s hex s%0d c%0d", name, k, c), 16'(bus.hex),
                      16'(hex_tab[4*k +: 4]));
                check($sformatf("%s dp s%0d c%0d", name, k, c), 16'(bus.dp),
                      16'(dp_tab[k]));
            end
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.lz_blank = 1'b0;
        bus.enable   = 1'b0;

        // Asynchronous reset before the first clock edge
        #3 rst_n = 1'b0;
        #1;
        check("reset an", 16'(bus.an), 16'hF);
        check("reset hex", 16'(bus.hex), 16'h0);
        check("reset dp", 16'(bus.dp), 16'h1);
        check("reset idx", 16'(bus.digit_idx), 16'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Plain scan of 0x1234
        load_paused(16'h1234, 4'b0000);
        check("load edge an", 16'(bus.an), 16'hF);
        run_frame("f1234", 16'h7BDE, 16'h1234, 4'hF);
        check("frame end idx", 16'(bus.digit_idx), 16'h0);

        // Leading-zero suppression of 0x0050
        bus.lz_blank = 1'b1;
        load_paused(16'h0050, 4'b0000);
        run_frame("f0050", 16'hFFDE, 16'h0050, 4'hF);

        // A decimal point stops suppression at its digit
        load_paused(16'h0003, 4'b0100);
        run_frame("f0003", 16'hFBDE, 16'h0003, 4'hB);

        // Load on the slot-wrap edge
        bus.lz_blank = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre-wrap idx", 16'(bus.digit_idx), 16'h0);
        bus.load  = 1'b1;
        bus.value = 16'hABCD;
        bus.dp_in = 4'b0000;
        tick();
        bus.load = 1'b0;
        check("wrap edge hex", 16'(bus.hex), 16'h3);
        check("wrap edge an", 16'(bus.an), 16'hE);
        check("wrap edge idx", 16'(bus.digit_idx), 16'h1);
        tick();
        check("post-wrap hex", 16'(bus.hex), 16'hC);
        check("post-wrap an", 16'(bus.an), 16'hF);
        check("post-wrap dp", 16'(bus.dp), 16'h1);

        // Pause for 20 cycles once prescaler value 4 has been used
        for (int i = 0; i < 4; i++) tick();
        check("pre-pause an", 16'(bus.an), 16'hD);
        bus.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("pause an %0d", i), 16'(bus.an), 16'hF);
            check($sformatf("pause idx %0d", i), 16'(bus.digit_idx), 16'h1);
        end
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("resume an %0d", i), 16'(bus.an), 16'hD);
            check($sformatf("resume hex %0d", i), 16'(bus.hex), 16'hC);
        end
        tick();
        check("resume slot end an", 16'(bus.an), 16'hF);
        check("resume slot end hex", 16'(bus.hex), 16'hB);
        check("resume slot end idx", 16'(bus.digit_idx), 16'h2);

        // Asynchronous reset between edges mid-scan
        tick();
        tick();
        check("pre-reset an", 16'(bus.an), 16'hB);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset an", 16'(bus.an), 16'hF);
        check("mid reset hex", 16'(bus.hex), 16'h0);
        check("mid reset dp", 16'(bus.dp), 16'h1);
        check("mid reset idx", 16'(bus.digit_idx), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("restart an c0", 16'(bus.an), 16'hF);
        tick();
        tick();
        check("restart an c2", 16'(bus.an), 16'hE);
        check("restart hex", 16'(bus.hex), 16'h0);
        check("restart dp", 16'(bus.dp), 16'h1);
        check("restart idx", 16'(bus.digit_idx), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led_scan_mux.md
Name: led_scan_mux

Overview:
Time-multiplexed scan driver for a common-anode multi-digit 7-segment display. It holds a shadow copy of an NDIGITS-nibble display value and steps through the digits at a prescaled rate. It drives the current nibble to the downstream hex-to-segment decoder, and drives the active-low digit anodes and decimal point. Features: inter-digit blanking (anti-ghosting), leading-zero suppression and scan pause.

Parameters:
NDIGITS, 4, number of digits scanned (2..8)
PRESCALE, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (0 .. PRESCALE-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  capture value/dp_in into shadow registers
value  in  4*NDIGITS  display value; nibble i = digit i, digit 0 rightmost
dp_in  in  NDIGITS  decimal point request per digit, active-high
lz_blank  in  1  enable leading-zero suppression
enable  in  1  scan run; 0 = pause with display dark
hex  out  4  nibble of the current digit, to the decoder HEX input
dp  out  1  decimal point, active-low
an  out  NDIGITS  digit anode enables, active-low, at most one low
digit_idx  out  clog2(NDIGITS)  index of the current digit

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: shadow value=0, shadow dp=0, prescaler=0, digit_idx=0, an=all 1, hex=0, dp=1. All outputs take these values immediately on rst_n low, independent of clk.
- Shadow update: on an edge with load=1, shadow value and shadow dp take value and dp_in. No other path modifies the shadow.
- Prescaler: counts 0..PRESCALE-1 while enable=1. At PRESCALE-1 it wraps to 0 and digit_idx increments. digit_idx wraps from NDIGITS-1 to 0.
- enable=0: prescaler and digit_idx hold. an is forced all 1 from the next edge. When enable returns to 1, counting resumes from the held count.
- Registered outputs: hex, dp and an update every edge from the pre-edge state, i.e. out(t+1) = f(shadow(t), prescaler(t), digit_idx(t)).
  - hex = shadow nibble[digit_idx].
  - dp = ~shadow_dp[digit_idx].
  - an[digit_idx] = 0 only if all of the following hold: enable=1, prescaler >= BLANK_CYCLES, and the digit is not suppressed. All other an bits = 1.
  - digit_idx is the counter itself (not delayed).
- Load latency: load sampled at edge N; hex/dp reflect the new shadow at edge N+1 if that digit is current.
- Leading-zero suppression, when lz_blank=1:
  - Digit i (i >= 1) is suppressed iff, for every j in i..NDIGITS-1, nibble j == 0 and shadow_dp[j] == 0.
  - Digit 0 is never suppressed.
  - Suppression is combinational on the shadow and feeds the an register.
  - lz_blank=0 disables suppression.
- Suppressed digit: its slot still elapses at full length with an all 1. hex still carries 0.
- Simultaneous load and slot wrap on the same edge: the new digit_idx and the new shadow are both used at the next edge. No mixing within a single output update.
- Slot timing per enabled slot: an dark for BLANK_CYCLES cycles, then low for PRESCALE-BLANK_CYCLES cycles. Full frame = NDIGITS*PRESCALE cycles.

Test Plan:
- Setup: NDIGITS=4, PRESCALE=8, BLANK_CYCLES=2. Reset, then load value=0x1234, dp_in=0, lz_blank=0, enable=1 -> an cycles 1110,1101,1011,0111, each low 6 cycles after 2 dark cycles. hex 4,3,2,1 in step with the anodes; dp=1 throughout.
- lz_blank=1, load 0x0050 -> slots 3 and 2 give an=1111 for all 8 cycles. Slot 1 gives hex=5 with an=1101; slot 0 gives hex=0 with an=1110.
- lz_blank=1, load value=0x0003, dp_in=0100 -> digit 3 dark. Digit 2 lit with hex=0 and dp=0. Digit 1 lit with hex=0 and dp=1. Digit 0 lit with hex=3.
- Pulse load with 0xABCD on the same edge the prescaler wraps from 7 to 0 -> at the next edge hex shows the new nibble for the new digit_idx. No stale nibble appears on the new digit.
- Drop enable for 20 cycles mid-slot at prescaler=4 -> an=1111 from the next edge, digit_idx constant. On re-enable the slot completes with the remaining 3 lit cycles.
- Assert rst_n low mid-scan, asynchronously between edges -> an=1111, hex=0, dp=1, digit_idx=0 immediately. After release, scanning restarts at digit 0 with shadow=0.
